// File: rtl/dcache_pkg.sv
// Shared widths and FSM encoding for the MEM-stage data cache.
// Direct-mapped, 32 lines of 256 bits, 32-bit byte addresses.
package dcache_pkg;

  localparam int NUM_LINES = 32;
  localparam int ADDR_W    = 32;
  localparam int TAG_W     = 22;
  localparam int IDX_W     = 5;
  localparam int OFF_W     = 5;
  localparam int LINE_W    = 256;
  localparam int WORD_W    = 32;
  localparam int WORDS     = LINE_W / WORD_W;

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    ALLOCATE,
    REFILL
  } state_t;

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side bundles of the data cache.
// The cache is the slave of the CPU bundle and the master of the memory one.
interface dcache_cpu_if;
  import dcache_pkg::*;

  logic              p1_req_i;
  logic              p1_write_i;
  logic [ADDR_W-1:0] p1_addr_i;
  logic [WORD_W-1:0] p1_data_i;
  logic [WORD_W-1:0] p1_data_o;
  logic              p1_stall_o;

  modport master (
    output p1_req_i, p1_write_i, p1_addr_i, p1_data_i,
    input  p1_data_o, p1_stall_o
  );

  modport slave (
    input  p1_req_i, p1_write_i, p1_addr_i, p1_data_i,
    output p1_data_o, p1_stall_o
  );
endinterface

interface dcache_mem_if;
  import dcache_pkg::*;

  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  modport master (
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );

  modport slave (
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/dcache_sram.sv
// Tag/state and data arrays: one combinational read port and
// one write port whose line write is gated per 32-bit word.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  rdIdx,
  output logic              rdValid,
  output logic              rdDirty,
  output logic [TAG_W-1:0]  rdTag,
  output logic [LINE_W-1:0] rdLine,
  input  logic              we,
  input  logic [IDX_W-1:0]  wIdx,
  input  logic              wValid,
  input  logic              wDirty,
  input  logic [TAG_W-1:0]  wTag,
  input  logic [WORDS-1:0]  wordEn,
  input  logic [LINE_W-1:0] wLine
);

  logic [NUM_LINES-1:0] validQ;
  logic [NUM_LINES-1:0] dirtyQ;
  logic [TAG_W-1:0]     tagArr  [NUM_LINES];
  logic [LINE_W-1:0]    dataArr [NUM_LINES];

  assign rdValid = validQ[rdIdx];
  assign rdDirty = dirtyQ[rdIdx];
  assign rdTag   = tagArr[rdIdx];
  assign rdLine  = dataArr[rdIdx];

  // Line state bits; reset invalidates every line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      validQ <= '0;
      dirtyQ <= '0;
    end else if (we) begin
      validQ[wIdx] <= wValid;
      dirtyQ[wIdx] <= wDirty;
    end
  end

  // Tag and data storage; contents are meaningless until validated.
  always_ff @(posedge clk_i) begin
    if (we) begin
      tagArr[wIdx] <= wTag;
      for (int w = 0; w < WORDS; w++) begin
        if (wordEn[w]) begin
          dataArr[wIdx][w*WORD_W +: WORD_W] <= wLine[w*WORD_W +: WORD_W];
        end
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage L1 data cache controller: hit detect, word select/merge,
// miss FSM with writeback/refill handshake to off-chip memory.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  dcache_cpu_if.slave   cpu,
  dcache_mem_if.master  mem
);

  state_t state, stateNxt;

  logic [TAG_W-1:0]  reqTag;
  logic [IDX_W-1:0]  reqIdx;
  logic [2:0]        reqWord;
  logic              rdValid, rdDirty;
  logic [TAG_W-1:0]  rdTag;
  logic [LINE_W-1:0] rdLine;
  logic              we, wValid, wDirty;
  logic [TAG_W-1:0]  wTag;
  logic [WORDS-1:0]  wordEn;
  logic [LINE_W-1:0] wLine;
  logic [LINE_W-1:0] refillBuf;
  logic [WORD_W-1:0] lastData;
  logic [WORD_W-1:0] hitWord;
  logic              hit, loadHit;
  logic              unusedAddr;

  assign reqTag     = cpu.p1_addr_i[ADDR_W-1 -: TAG_W];
  assign reqIdx     = cpu.p1_addr_i[OFF_W +: IDX_W];
  assign reqWord    = cpu.p1_addr_i[4:2];
  assign unusedAddr = ^cpu.p1_addr_i[1:0];

  dcache_sram uSram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .rdIdx   (reqIdx),
    .rdValid (rdValid),
    .rdDirty (rdDirty),
    .rdTag   (rdTag),
    .rdLine  (rdLine),
    .we      (we),
    .wIdx    (reqIdx),
    .wValid  (wValid),
    .wDirty  (wDirty),
    .wTag    (wTag),
    .wordEn  (wordEn),
    .wLine   (wLine)
  );

  assign hit     = rdValid && (rdTag == reqTag);
  assign hitWord = rdLine[{reqWord, 5'b0} +: WORD_W];
  assign loadHit = (state == IDLE) && cpu.p1_req_i
                && !cpu.p1_write_i && hit;

  assign cpu.p1_data_o = loadHit ? hitWord : lastData;

  // Remember the last load so the output holds between accesses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lastData <= '0;
    else if (loadHit) lastData <= hitWord;
  end

  // Capture the fetched line on the ack that ends ALLOCATE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) refillBuf <= '0;
    else if (state == ALLOCATE && mem.mem_ack_i) refillBuf <= mem.mem_data_i;
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else state <= stateNxt;
  end

  // Next state, stall, memory handshake and array write control.
  always_comb begin
    stateNxt         = state;
    cpu.p1_stall_o   = 1'b0;
    mem.mem_enable_o = 1'b0;
    mem.mem_write_o  = 1'b0;
    mem.mem_addr_o   = '0;
    mem.mem_data_o   = '0;
    we               = 1'b0;
    wValid           = rdValid;
    wDirty           = rdDirty;
    wTag             = rdTag;
    wordEn           = '0;
    wLine            = {WORDS{cpu.p1_data_i}};
    unique case (state)
      IDLE: begin
        if (cpu.p1_req_i) begin
          if (!hit) begin
            cpu.p1_stall_o = 1'b1;
            stateNxt       = MISS;
          end else if (cpu.p1_write_i) begin
            we              = 1'b1;
            wDirty          = 1'b1;
            wordEn[reqWord] = 1'b1;
          end
        end
      end
      MISS: begin
        cpu.p1_stall_o = 1'b1;
        stateNxt = (rdValid && rdDirty) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        cpu.p1_stall_o   = 1'b1;
        mem.mem_enable_o = 1'b1;
        mem.mem_write_o  = 1'b1;
        mem.mem_addr_o   = {rdTag, reqIdx, 5'b0};
        mem.mem_data_o   = rdLine;
        if (mem.mem_ack_i) stateNxt = ALLOCATE;
      end
      ALLOCATE: begin
        cpu.p1_stall_o   = 1'b1;
        mem.mem_enable_o = 1'b1;
        mem.mem_addr_o   = {reqTag, reqIdx, 5'b0};
        if (mem.mem_ack_i) stateNxt = REFILL;
      end
      REFILL: begin
        cpu.p1_stall_o = 1'b1;
        we             = 1'b1;
        wValid         = 1'b1;
        wDirty         = 1'b0;
        wTag           = reqTag;
        wordEn         = '1;
        wLine          = refillBuf;
        stateNxt       = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a latency-programmable
// line memory model driven from the stimulus sequence.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  dcache_cpu_if cpu();
  dcache_mem_if mem();

  dcache_ctrl dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .cpu   (cpu),
    .mem   (mem)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  logic [LINE_W-1:0] memArr [logic [31:0]];

  int          stallCycles, nFetch, nWb, fCyc, wCyc;
  logic [31:0] fAddr, wbAddr;
  logic [LINE_W-1:0] wbLine;
  logic [LINE_W-1:0] expLine;

  task automatic chk(input string tag,
                     input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] lineFor(input logic [31:0] la);
    logic [LINE_W-1:0] l;
    for (int w = 0; w < WORDS; w++)
      l[w*32 +: 32] = 32'h7000_0000 | (la + 32'(w * 4));
    return l;
  endfunction

  // Present one access and play memory until the stall clears.
  task automatic run(input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input int lat);
    int phaseCnt;
    bit done;
    logic [31:0] la;
    @(negedge clk_i);
    cpu.p1_req_i   = 1'b1;
    cpu.p1_write_i = wr;
    cpu.p1_addr_i  = a;
    cpu.p1_data_i  = d;
    stallCycles = 0; nFetch = 0; nWb = 0; fCyc = 0; wCyc = 0;
    fAddr = '0; wbAddr = '0; wbLine = '0;
    phaseCnt = 0; done = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      #1;
      mem.mem_ack_i = 1'b0;
      if (!cpu.p1_stall_o) begin
        done = 1;
        break;
      end
      stallCycles++;
      if (mem.mem_enable_o) begin
        if (mem.mem_write_o) wCyc++;
        else fCyc++;
        phaseCnt++;
        if (phaseCnt == lat) begin
          phaseCnt = 0;
          mem.mem_ack_i = 1'b1;
          la = mem.mem_addr_o;
          if (mem.mem_write_o) begin
            nWb++;
            wbAddr = la;
            wbLine = mem.mem_data_o;
            memArr[la] = mem.mem_data_o;
          end else begin
            nFetch++;
            fAddr = la;
            mem.mem_data_i = memArr.exists(la) ? memArr[la] : lineFor(la);
          end
        end
      end
      @(negedge clk_i);
    end
    mem.mem_ack_i = 1'b0;
    chk("stall_bounded", 1'(done), 1'b1);
  endtask

  initial begin
    cpu.p1_req_i   = 1'b0;
    cpu.p1_write_i = 1'b0;
    cpu.p1_addr_i  = '0;
    cpu.p1_data_i  = '0;
    mem.mem_ack_i  = 1'b0;
    mem.mem_data_i = '0;

    expLine = lineFor(32'h400);
    expLine[31:0] = 32'h1234_5678;
    memArr[32'h400] = expLine;

    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_enable", mem.mem_enable_o, 1'b0);
    chk("rst_write", mem.mem_write_o, 1'b0);
    chk("rst_stall", cpu.p1_stall_o, 1'b0);
    chk("rst_data", cpu.p1_data_o, 32'h0);
    chk("rst_maddr", mem.mem_addr_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Cold load, latency 4
    run(1'b0, 32'h400, 32'h0, 4);
    chk("t1_stall", stallCycles, 7);
    chk("t1_nfetch", nFetch, 1);
    chk("t1_nwb", nWb, 0);
    chk("t1_faddr", fAddr, 32'h400);
    chk("t1_fcyc", fCyc, 4);
    chk("t1_data", cpu.p1_data_o, 32'h1234_5678);

    // Repeat load hits with no stall
    run(1'b0, 32'h400, 32'h0, 4);
    chk("t2_stall", stallCycles, 0);
    chk("t2_data", cpu.p1_data_o, 32'h1234_5678);

    // Store hit, then conflicting load forces writeback
    run(1'b1, 32'h404, 32'hDEAD_BEEF, 3);
    chk("t3_st_stall", stallCycles, 0);
    run(1'b0, 32'h804, 32'h0, 3);
    expLine[63:32] = 32'hDEAD_BEEF;
    chk("t3_stall", stallCycles, 9);
    chk("t3_nwb", nWb, 1);
    chk("t3_wbaddr", wbAddr, 32'h400);
    chk("t3_wbline", wbLine, expLine);
    chk("t3_wcyc", wCyc, 3);
    chk("t3_nfetch", nFetch, 1);
    chk("t3_faddr", fAddr, 32'h800);
    chk("t3_data", cpu.p1_data_o, 32'h7000_0804);

    // Clean victim: fetch only
    run(1'b0, 32'hC04, 32'h0, 2);
    chk("t4_stall", stallCycles, 5);
    chk("t4_nwb", nWb, 0);
    chk("t4_wcyc", wCyc, 0);
    chk("t4_faddr", fAddr, 32'hC00);
    chk("t4_data", cpu.p1_data_o, 32'h7000_0C04);

    // Reset during ALLOCATE
    @(negedge clk_i);
    cpu.p1_req_i   = 1'b1;
    cpu.p1_write_i = 1'b0;
    cpu.p1_addr_i  = 32'h1000;
    begin
      bit inAlloc;
      inAlloc = 0;
      for (int i = 0; i < 20; i++) begin
        #1;
        if (mem.mem_enable_o && !mem.mem_write_o) begin
          inAlloc = 1;
          break;
        end
        @(negedge clk_i);
      end
      chk("t5_alloc", 1'(inAlloc), 1'b1);
    end
    cpu.p1_req_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("t5_rst_enable", mem.mem_enable_o, 1'b0);
    chk("t5_rst_stall", cpu.p1_stall_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    mem.mem_ack_i  = 1'b1;
    mem.mem_data_i = {8{32'hBAD0_BAD0}};
    #1;
    chk("t5_stray_en", mem.mem_enable_o, 1'b0);
    @(negedge clk_i);
    mem.mem_ack_i = 1'b0;
    #1;
    chk("t5_stray_stall", cpu.p1_stall_o, 1'b0);
    run(1'b0, 32'h404, 32'h0, 1);
    chk("t5_stall", stallCycles, 4);
    chk("t5_nfetch", nFetch, 1);
    chk("t5_fcyc", fCyc, 1);
    chk("t5_data", cpu.p1_data_o, 32'hDEAD_BEEF);

    // Back-to-back misses with latency 20 and 1
    run(1'b0, 32'h2008, 32'h0, 20);
    chk("t6a_stall", stallCycles, 23);
    chk("t6a_fcyc", fCyc, 20);
    chk("t6a_nwb", nWb, 0);
    chk("t6a_data", cpu.p1_data_o, 32'h7000_2008);
    run(1'b0, 32'h3024, 32'h0, 1);
    chk("t6b_stall", stallCycles, 4);
    chk("t6b_data", cpu.p1_data_o, 32'h7000_3024);
    run(1'b1, 32'h3028, 32'hCAFE_F00D, 1);
    chk("t6c_stall", stallCycles, 0);
    run(1'b0, 32'h4020, 32'h0, 1);
    expLine = lineFor(32'h3020);
    expLine[95:64] = 32'hCAFE_F00D;
    chk("t6d_stall", stallCycles, 5);
    chk("t6d_wbaddr", wbAddr, 32'h3020);
    chk("t6d_wbline", wbLine, expLine);
    chk("t6d_wcyc", wCyc, 1);
    chk("t6d_fcyc", fCyc, 1);
    chk("t6d_data", cpu.p1_data_o, 32'h7000_4020);

    // Output holds with no request
    @(negedge clk_i);
    cpu.p1_req_i  = 1'b0;
    cpu.p1_addr_i = 32'h400;
    #1;
    chk("hold_data", cpu.p1_data_o, 32'h7000_4020);
    chk("hold_stall", cpu.p1_stall_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
